// File: rtl/ysyx_24070014_stream_mux_pkg.sv
// Shared definitions for ysyx_24070014_stream_mux: mode encoding, lock state
// and the channel-index width helper.
package ysyx_24070014_stream_mux_pkg;

  typedef enum logic {
    MODE_KEY = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_e;

  // Bits needed to index n channels (n >= 2).
  function automatic int unsigned ch_idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/ysyx_24070014_stream_mux_arb.sv
// Combinational grant selection: packet lock first, then key lookup
// (lowest matching index) or round-robin search starting at rr_ptr_i.
module ysyx_24070014_stream_mux_arb
  import ysyx_24070014_stream_mux_pkg::*;
#(
  parameter int unsigned NR_CH   = 4,
  parameter int unsigned KEY_LEN = 2
) (
  input  mode_e                          mode_i,
  input  logic [KEY_LEN-1:0]             sel_key_i,
  input  logic [NR_CH*KEY_LEN-1:0]       key_lut_i,
  input  logic [NR_CH-1:0]               valid_i,
  input  logic [ch_idx_w(NR_CH)-1:0]     rr_ptr_i,
  input  logic                           locked_i,
  input  logic [ch_idx_w(NR_CH)-1:0]     lock_ch_i,
  output logic [ch_idx_w(NR_CH)-1:0]     grant_o,
  output logic                           hit_o
);

  localparam int unsigned CW = ch_idx_w(NR_CH);

  int unsigned idx;

  always_comb begin
    grant_o = '0;
    hit_o   = 1'b0;
    idx     = 0;
    if (locked_i) begin
      grant_o = lock_ch_i;
      hit_o   = 1'b1;
    end else if (mode_i == MODE_RR) begin
      for (int unsigned k = 0; k < NR_CH; k++) begin
        idx = 32'(rr_ptr_i) + k;
        if (idx >= NR_CH) idx = idx - NR_CH;
        if (!hit_o && valid_i[CW'(idx)]) begin
          hit_o   = 1'b1;
          grant_o = CW'(idx);
        end
      end
    end else begin
      for (int unsigned n = 0; n < NR_CH; n++) begin
        if (!hit_o && (key_lut_i[n*KEY_LEN +: KEY_LEN] == sel_key_i)) begin
          hit_o   = 1'b1;
          grant_o = CW'(n);
        end
      end
    end
  end

endmodule

// File: rtl/ysyx_24070014_stream_mux.sv
// Keyed / round-robin stream multiplexer with packet lock and a one-entry
// output register. Define YSYX_24070014_STREAM_MUX_RR_EN to enable round-robin mode.
module ysyx_24070014_stream_mux
  import ysyx_24070014_stream_mux_pkg::*;
#(
  parameter int unsigned NR_CH    = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NR_CH-1:0]              in_valid,
  output logic [NR_CH-1:0]              in_ready,
  input  logic [NR_CH*DATA_LEN-1:0]     in_data,
  input  logic [NR_CH-1:0]              in_last,
  input  logic [NR_CH*KEY_LEN-1:0]      key_lut,
  input  logic [KEY_LEN-1:0]            sel_key,
  input  logic                          mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_LEN-1:0]           out_data,
  output logic                          out_last,
  output logic [ch_idx_w(NR_CH)-1:0]    out_ch,
  output logic                          miss
);

  localparam int unsigned CW = ch_idx_w(NR_CH);

  lock_e               lk_q, lk_d;
  logic [CW-1:0]       lock_ch_q, lock_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [CW-1:0]       out_ch_q, out_ch_d;
  logic                miss_q, miss_d;

  mode_e               eff_mode;
  logic [CW-1:0]       rr_ptr;
  logic [CW-1:0]       grant;
  logic                hit;
  logic                locked;
  logic                loadable;
  logic                take;
  logic                beat_last;

  assign locked = (lk_q == LK_HELD);

  ysyx_24070014_stream_mux_arb #(
    .NR_CH   (NR_CH),
    .KEY_LEN (KEY_LEN)
  ) u_arb (
    .mode_i    (eff_mode),
    .sel_key_i (sel_key),
    .key_lut_i (key_lut),
    .valid_i   (in_valid),
    .rr_ptr_i  (rr_ptr),
    .locked_i  (locked),
    .lock_ch_i (lock_ch_q),
    .grant_o   (grant),
    .hit_o     (hit)
  );

`ifdef YSYX_24070014_STREAM_MUX_RR_EN
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;

  assign eff_mode = mode_e'(mode);
  assign rr_ptr   = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take && beat_last) begin
      rr_ptr_d = (32'(grant) == NR_CH - 1) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  logic mode_unused;

  assign mode_unused = mode;
  assign eff_mode    = MODE_KEY;
  assign rr_ptr      = '0;
`endif

  always_comb begin
    loadable  = !out_valid_q || out_ready;
    in_ready  = '0;
    // in_ready is gated by rst_n so it is low throughout reset, not only after it.
    if (rst_n && loadable && hit) in_ready[grant] = 1'b1;
    take      = |(in_ready & in_valid);
    beat_last = in_last[grant];

    lk_d        = lk_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    miss_d      = !locked && (eff_mode == MODE_KEY) && !hit && (|in_valid);

    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(grant)*DATA_LEN +: DATA_LEN];
      out_last_d  = beat_last;
      out_ch_d    = grant;
      if (beat_last) begin
        lk_d = LK_OPEN;
      end else begin
        lk_d      = LK_HELD;
        lock_ch_d = grant;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_q        <= LK_OPEN;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      miss_q      <= 1'b0;
    end else begin
      lk_q        <= lk_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      miss_q      <= miss_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_ysyx_24070014_stream_mux.sv
// Directed + randomized bench for ysyx_24070014_stream_mux against a
// transaction-level reference model.
module tb_ysyx_24070014_stream_mux;

  localparam int unsigned NR_CH    = 4;
  localparam int unsigned KEY_LEN  = 2;
  localparam int unsigned DATA_LEN = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NR_CH-1:0]          in_valid;
  logic [NR_CH-1:0]          in_ready;
  logic [NR_CH*DATA_LEN-1:0] in_data;
  logic [NR_CH-1:0]          in_last;
  logic [NR_CH*KEY_LEN-1:0]  key_lut;
  logic [KEY_LEN-1:0]        sel_key;
  logic                      mode;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_LEN-1:0]       out_data;
  logic                      out_last;
  logic [1:0]                out_ch;
  logic                      miss;

  always #5 clk = ~clk;

  ysyx_24070014_stream_mux #(
    .NR_CH    (NR_CH),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .key_lut   (key_lut),
    .sel_key   (sel_key),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .miss      (miss)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the output register contents and packet/pointer bookkeeping.
  bit                  m_init   = 1'b0;
  bit                  m_ov     = 1'b0;
  logic [DATA_LEN-1:0] m_od     = '0;
  bit                  m_ol     = 1'b0;
  int                  m_och    = 0;
  bit                  m_locked = 1'b0;
  int                  m_lch    = 0;
  int                  m_rr     = 0;
  bit                  m_miss   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int key_hit(input logic [NR_CH*KEY_LEN-1:0] lut, input logic [KEY_LEN-1:0] k);
    for (int n = 0; n < NR_CH; n++)
      if (lut[n*KEY_LEN +: KEY_LEN] == k) return n;
    return -1;
  endfunction

  function automatic bit rr_mode();
`ifdef YSYX_24070014_STREAM_MUX_RR_EN
    return mode;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_grant();
    if (m_locked) return m_lch;
    if (rr_mode()) begin
      for (int k = 0; k < NR_CH; k++) begin
        int c;
        c = (m_rr + k) % NR_CH;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    return key_hit(key_lut, sel_key);
  endfunction

  // One clock: check in_ready before the edge, advance model at the edge, check outputs after.
  task automatic cycle();
    int               g;
    logic [NR_CH-1:0] er;
    bit               take;
    #1;
    g  = model_grant();
    er = '0;
    if (rst_n && (!m_ov || out_ready) && g >= 0) er[g] = 1'b1;
    chk("in_ready", 64'(in_ready), 64'(er));
    take = (g >= 0) && er[g] && in_valid[g];
    @(posedge clk);
    if (!rst_n) begin
      m_init = 1'b1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_och = 0;
      m_locked = 1'b0; m_lch = 0; m_rr = 0; m_miss = 1'b0;
    end else begin
      m_miss = !m_locked && !rr_mode() && (key_hit(key_lut, sel_key) < 0) && (|in_valid);
      if (take) begin
        m_ov  = 1'b1;
        m_od  = in_data[g*DATA_LEN +: DATA_LEN];
        m_ol  = in_last[g];
        m_och = g;
        if (in_last[g]) begin
          m_locked = 1'b0;
          m_rr     = (g + 1) % NR_CH;
        end else begin
          m_locked = 1'b1;
          m_lch    = g;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    #1;
    if (m_init) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data",  64'(out_data),  64'(m_od));
      chk("out_last",  64'(out_last),  64'(m_ol));
      chk("out_ch",    64'(out_ch),    64'(m_och));
      chk("miss",      64'(miss),      64'(m_miss));
    end
  endtask

  task automatic idle();
    in_valid = '0;
    in_last  = '0;
  endtask

  task automatic drive(input int ch, input logic [DATA_LEN-1:0] d, input bit last);
    in_valid = '0;
    in_last  = '0;
    in_valid[ch] = 1'b1;
    in_last[ch]  = last;
    in_data[ch*DATA_LEN +: DATA_LEN] = d;
  endtask

  initial begin
    logic [DATA_LEN-1:0] held;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    key_lut   = 8'h1B;   // ch0=3 ch1=2 ch2=1 ch3=0
    sel_key   = '0;
    mode      = 1'b0;
    out_ready = 1'b1;

    // Reset state
    cycle();
    cycle();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_ch",    64'(out_ch),    64'd0);
    rst_n = 1'b1;

    // Key hit: sel_key=2 selects ch1
    sel_key = 2'd2;
    drive(1, 32'hA5, 1'b1);
    cycle();
    chk("key_data", 64'(out_data), 64'hA5);
    chk("key_ch",   64'(out_ch),   64'd1);
    idle();
    cycle();

    // Key miss: key 0 absent from table
    key_lut = 8'h5B;     // ch0=3 ch1=2 ch2=1 ch3=1
    sel_key = 2'd0;
    drive(0, 32'h1234, 1'b1);
    cycle();
    chk("miss_pulse", 64'(miss),      64'd1);
    chk("miss_valid", 64'(out_valid), 64'd0);
    idle();
    cycle();
    chk("miss_clear", 64'(miss), 64'd0);
    key_lut = 8'h1B;

    // Mode input with all channels presenting single-beat packets
    rst_n = 1'b0;
    cycle();
    rst_n    = 1'b1;
    mode     = 1'b1;
    sel_key  = 2'd2;
    in_valid = '1;
    in_last  = '1;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < NR_CH; c++) in_data[c*DATA_LEN +: DATA_LEN] = $urandom;
      cycle();
`ifdef YSYX_24070014_STREAM_MUX_RR_EN
      chk("rr_seq", 64'(out_ch), 64'(i % NR_CH));
`else
      chk("mode_ignored", 64'(out_ch), 64'd1);
`endif
    end
    mode = 1'b0;
    idle();
    cycle();

    // Packet lock: 3 beats on ch2, key moved to ch0 after the first
    sel_key = 2'd1;
    drive(2, 32'hB001, 1'b0);
    cycle();
    chk("lock_b1", 64'(out_ch), 64'd2);
    sel_key = 2'd3;
    drive(2, 32'hB002, 1'b0);
    in_valid[0] = 1'b1;
    in_last[0]  = 1'b1;
    cycle();
    chk("lock_b2", 64'(out_ch), 64'd2);
    drive(2, 32'hB003, 1'b1);
    in_valid[0] = 1'b1;
    in_last[0]  = 1'b1;
    cycle();
    chk("lock_b3", 64'(out_ch), 64'd2);
    chk("lock_b3_last", 64'(out_last), 64'd1);
    drive(0, 32'hC000, 1'b1);
    cycle();
    chk("lock_release", 64'(out_ch), 64'd0);
    idle();
    cycle();

    // Back-pressure then drain+reload in one cycle
    sel_key = 2'd2;
    drive(1, 32'hD00D, 1'b1);
    cycle();
    held = out_data;
    out_ready = 1'b0;
    drive(1, 32'hE00E, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_stable", 64'(out_data), 64'hD00D);
      chk("bp_ready",  64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_reload_valid", 64'(out_valid), 64'd1);
    chk("bp_reload_data",  64'(out_data),  64'hE00E);
    chk("bp_held_seen",    64'(held),      64'hD00D);
    idle();
    cycle();

    // Reset mid-packet
    sel_key = 2'd1;
    drive(2, 32'hF001, 1'b0);
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
`ifdef YSYX_24070014_STREAM_MUX_RR_EN
    mode     = 1'b1;
    in_valid = '1;
    in_last  = '1;
    cycle();
    chk("mid_rst_rrptr", 64'(out_ch), 64'd0);
    mode = 1'b0;
    idle();
    cycle();
`endif
    sel_key = 2'd3;
    drive(0, 32'hF0F0, 1'b1);
    cycle();
    chk("mid_rst_new_valid", 64'(out_valid), 64'd1);
    chk("mid_rst_new_ch",    64'(out_ch),    64'd0);
    idle();
    cycle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 15) == 0) key_lut = NR_CH*KEY_LEN'($urandom);
      if ($urandom_range(0, 7) == 0)  sel_key = KEY_LEN'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 1'($urandom);
      in_valid  = NR_CH'($urandom);
      for (int c = 0; c < NR_CH; c++) begin
        in_data[c*DATA_LEN +: DATA_LEN] = $urandom;
        in_last[c] = ($urandom_range(0, 2) == 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24070014_stream_mux.md
YSYX_24070014_STREAM_MUX -- requirements
Module: ysyx_24070014_stream_mux

Interface
REQ-001 Parameter NR_CH, default 4, SHALL set the number of input channels (2..16).
REQ-002 Parameter KEY_LEN, default 2, SHALL set the channel key width.
REQ-003 Parameter DATA_LEN, default 32, SHALL set the payload width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  SHALL be the synchronous, active-low reset.
REQ-006 in_valid  in  NR_CH  SHALL carry per-channel valid.
REQ-007 in_ready  out  NR_CH  SHALL carry per-channel ready.
REQ-008 in_data  in  NR_CH*DATA_LEN  SHALL carry packed payloads; channel n occupies bits [DATA_LEN*(n+1)-1 : DATA_LEN*n].
REQ-009 in_last  in  NR_CH  SHALL carry per-channel end-of-packet.
REQ-010 key_lut  in  NR_CH*KEY_LEN  SHALL carry packed channel keys, same packing rule as in_data.
REQ-011 sel_key  in  KEY_LEN  SHALL be the requested key in key mode.
REQ-012 mode  in  1  SHALL select key mode (0) or round-robin mode (1).
REQ-013 out_valid / out_ready / out_data / out_last  out/in/out/out  1/1/DATA_LEN/1  SHALL form the output stream.
REQ-014 out_ch  out  $clog2(NR_CH)  SHALL carry the source channel index of the current output beat.
REQ-015 miss  out  1  SHALL pulse for one cycle when key mode is unlocked, sel_key matches no key_lut entry, and some in_valid is high.

Function
REQ-016 Handshake: a beat transfers on an input channel when its in_valid and in_ready are both high; on the output when out_valid and out_ready are both high.
REQ-017 A one-entry output register SHALL give one cycle of latency from input handshake to out_valid.
REQ-018 The output register SHALL be loadable when it is empty or drains in the same cycle; in_ready[g] = loadable AND (g is the grant); all other in_ready bits SHALL be 0.
REQ-019 Key mode: the grant SHALL be the lowest index n with key_lut[n]==sel_key; duplicate keys SHALL resolve to the lowest index.
REQ-020 Key miss: no in_ready bit SHALL be asserted and no beat SHALL be forwarded.
REQ-021 Round-robin mode: the grant SHALL be the first valid channel at or after rr_ptr, wrapping modulo NR_CH.
REQ-022 Packet lock: after a transferred beat with in_last=0, the grant SHALL hold on that channel until a transferred beat with in_last=1; sel_key, mode and rr_ptr changes SHALL be ignored while locked.
REQ-023 After a transferred last beat, rr_ptr SHALL become (grant+1) mod NR_CH, wrapping from NR_CH-1 to 0.
REQ-024 Back-pressure: while out_valid=1 and out_ready=0, out_data, out_last and out_ch SHALL remain stable.
REQ-025 Full throughput: with out_ready held at 1, one beat per cycle SHALL be sustained, including across packet boundaries between different channels.

Reset
REQ-026 While rst_n=0 at a clock edge: out_valid=0, in_ready=0, miss=0, lock cleared, rr_ptr=0, out_ch=0; out_data and out_last SHALL reset to 0.
REQ-027 Reset asserted mid-packet SHALL discard the held beat and the lock with no partial-packet recovery.

Configuration
REQ-028 With macro YSYX_24070014_STREAM_MUX_RR_EN defined, round-robin mode and rr_ptr SHALL exist.
REQ-029 Without YSYX_24070014_STREAM_MUX_RR_EN, mode SHALL be ignored and the block SHALL always operate in key mode; the port list SHALL be unchanged.

Structure
REQ-030 A shared package SHALL hold the mode encoding constants (MODE_KEY=0, MODE_RR=1) and a channel-index width function.
REQ-031 Grant selection SHALL be one sub-module, ysyx_24070014_stream_mux_arb, that is combinational from key/valid/rr_ptr/lock to grant plus a hit flag.

Verification
REQ-032 Key mode, NR_CH=4, key_lut={3,2,1,0}, sel_key=2, ch1 sends 0xA5 with last=1 -> out_data=0xA5, out_ch=1, one cycle later.
REQ-033 Key mode, sel_key absent from key_lut, ch0 valid -> miss=1 for one cycle, in_ready=0, out_valid stays 0.
REQ-034 RR mode, all channels valid, single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 3-beat packet on ch2 with sel_key changed after beat 1 -> all 3 beats taken from ch2, then grant follows the new key.
REQ-036 out_ready=0 for 5 cycles with out_valid=1 -> out_data stable, in_ready all 0; out_ready=1 -> drain and reload in the same cycle.
REQ-037 rst_n=0 mid-packet -> next cycle out_valid=0, rr_ptr=0, lock cleared; a new packet on any channel is then accepted.
